// File: rtl/dual_sram_responder.sv
// dual_sram_responder
// Instruction/data memory model serving a CPU's inst_sram_* and data_sram_*
// ports from one shared word array. Reads are synchronous with one cycle of
// latency and read-first ordering. Writes use per-byte enables. The array is
// zero-filled by hardware after reset. Out-of-range accesses raise a sticky
// error flag and bump a saturating counter.
module dual_sram_responder #(
  parameter int          AW        = 10,
  parameter logic [31:0] INST_BASE = 32'h1fc00000,
  parameter logic [31:0] DATA_BASE = 32'h1fc00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        init_done,
  output logic        err_flag,
  output logic [7:0]  err_count
);

  localparam int             DEPTH    = 2 ** AW;
  localparam int             HW       = 30 - AW;
  localparam logic [AW-1:0]  PTR_LAST = {AW{1'b1}};
  localparam logic [AW-1:0]  PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_ptr;
  logic [31:0]   r_mem [DEPTH];

  logic [31:0]   r_inst_rdata;
  logic [31:0]   r_data_rdata;
  logic          r_init_done;
  logic          r_err_flag;
  logic [7:0]    r_err_count;

  // Translate a virtual byte address into a word offset from a port's base.
  // Only the low 29 bits are physical, so the kseg bits are masked off first.
  function automatic logic [31:0] f_offset(input logic [31:0] addr,
                                           input logic [31:0] base);
    return (addr & 32'h1fffffff) - base;
  endfunction

  logic [31:0]   w_inst_off;
  logic [31:0]   w_data_off;
  logic          w_inst_in;
  logic          w_data_in;
  logic [AW-1:0] w_inst_idx;
  logic [AW-1:0] w_data_idx;
  logic          w_run;
  logic          w_inst_wr;
  logic          w_data_wr;
  logic          w_inst_err;
  logic          w_data_err;
  logic [1:0]    w_err_inc;
  logic [8:0]    w_err_sum;
  logic [7:0]    w_err_nxt;
  logic          w_unused_bits;

  assign w_inst_off = f_offset(inst_sram_addr, INST_BASE);
  assign w_data_off = f_offset(data_sram_addr, DATA_BASE);
  assign w_inst_in  = (w_inst_off[31:AW+2] == {HW{1'b0}});
  assign w_data_in  = (w_data_off[31:AW+2] == {HW{1'b0}});
  assign w_inst_idx = w_inst_off[AW+1:2];
  assign w_data_idx = w_data_off[AW+1:2];

  // Byte lanes within a word are irrelevant to a word-granular array.
  assign w_unused_bits = ^{w_inst_off[1:0], w_data_off[1:0]};

  assign w_run      = (r_state == ST_RUN);
  assign w_inst_wr  = w_run & inst_sram_en & w_inst_in & (|inst_sram_wen);
  assign w_data_wr  = w_run & data_sram_en & w_data_in & (|data_sram_wen);
  assign w_inst_err = w_run & inst_sram_en & ~w_inst_in;
  assign w_data_err = w_run & data_sram_en & ~w_data_in;

  // Both ports can err in the same cycle, so the counter may advance by two.
  assign w_err_inc = {1'b0, w_inst_err} + {1'b0, w_data_err};
  assign w_err_sum = {1'b0, r_err_count} + {7'd0, w_err_inc};
  assign w_err_nxt = w_err_sum[8] ? 8'hff : w_err_sum[7:0];

  // FSM state register: restarts the zero-fill on every reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: fill until the last word, then stay in RUN for good.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: begin
        if (r_ptr == PTR_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_INIT;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Fill pointer: walks the array once while in INIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= {AW{1'b0}};
    end else if (r_state == ST_INIT) begin
      r_ptr <= r_ptr + PTR_ONE;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Array writes: zero-fill in INIT; byte-masked port writes in RUN. The data
  // port's write is issued last, so it wins any byte both ports target.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_ptr] <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (w_inst_wr && inst_sram_wen[b]) begin
          r_mem[w_inst_idx][8*b +: 8] <= inst_sram_wdata[8*b +: 8];
        end
        if (w_data_wr && data_sram_wen[b]) begin
          r_mem[w_data_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read ports: sample the pre-write word; return zero during the fill or when
  // the address is out of range; hold the previous value when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inst_rdata <= 32'h0;
      r_data_rdata <= 32'h0;
    end else begin
      if (inst_sram_en) begin
        r_inst_rdata <= (w_run && w_inst_in) ? r_mem[w_inst_idx] : 32'h0;
      end else begin
        r_inst_rdata <= r_inst_rdata;
      end
      if (data_sram_en) begin
        r_data_rdata <= (w_run && w_data_in) ? r_mem[w_data_idx] : 32'h0;
      end else begin
        r_data_rdata <= r_data_rdata;
      end
    end
  end

  // init_done rises together with the transition into RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_init_done <= 1'b0;
    end else if ((r_state == ST_INIT) && (r_ptr == PTR_LAST)) begin
      r_init_done <= 1'b1;
    end else begin
      r_init_done <= r_init_done;
    end
  end

  // Error tracking: sticky flag plus saturating count, both cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_flag  <= 1'b0;
      r_err_count <= 8'h00;
    end else begin
      r_err_flag  <= r_err_flag | w_inst_err | w_data_err;
      r_err_count <= w_err_nxt;
    end
  end

  assign inst_sram_rdata = r_inst_rdata;
  assign data_sram_rdata = r_data_rdata;
  assign init_done       = r_init_done;
  assign err_flag        = r_err_flag;
  assign err_count       = r_err_count;

endmodule

// File: tb/tb_dual_sram_responder.sv
// Directed self-checking bench for dual_sram_responder with a 16-word array.
module tb_dual_sram_responder;

  localparam int          AW    = 4;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'hbfc00000;
  localparam logic [31:0] OOR   = 32'hbfc00040;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        init_done;
  logic        err_flag;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_errs   = 0;

  dual_sram_responder #(
    .AW        (AW),
    .INST_BASE (32'h1fc00000),
    .DATA_BASE (32'h1fc00000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .init_done       (init_done),
    .err_flag        (err_flag),
    .err_count       (err_count)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    inst_sram_en    = 1'b0;
    inst_sram_wen   = 4'h0;
    inst_sram_addr  = 32'h0;
    inst_sram_wdata = 32'h0;
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
  endtask

  task automatic inst_acc(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    inst_sram_en = 1'b1; inst_sram_wen = w; inst_sram_addr = a; inst_sram_wdata = d;
    tick();
    idle();
  endtask

  task automatic data_acc(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    data_sram_en = 1'b1; data_sram_wen = w; data_sram_addr = a; data_sram_wdata = d;
    tick();
    idle();
  endtask

  task automatic both_acc(input logic [31:0] ia, input logic [3:0] iw, input logic [31:0] id,
                          input logic [31:0] da, input logic [3:0] dw, input logic [31:0] dd);
    inst_sram_en = 1'b1; inst_sram_wen = iw; inst_sram_addr = ia; inst_sram_wdata = id;
    data_sram_en = 1'b1; data_sram_wen = dw; data_sram_addr = da; data_sram_wdata = dd;
    tick();
    idle();
  endtask

  // Count 16 fill cycles with init_done low, then expect it high.
  task automatic fill_check(input string tag);
    for (int c = 0; c < DEPTH; c++) begin
      check_val({tag, "_low"}, {31'd0, init_done}, 32'd0);
      if (c == 3) begin
        inst_sram_en = 1'b1; inst_sram_addr = OOR;
      end
      if (c == 14) begin
        data_sram_en = 1'b1; data_sram_wen = 4'hf;
        data_sram_addr = BASE + 32'd8; data_sram_wdata = 32'h12345678;
      end
      tick();
      idle();
    end
    check_val({tag, "_high"}, {31'd0, init_done}, 32'd1);
    check_val({tag, "_noerr"}, {31'd0, err_flag}, 32'd0);
    check_val({tag, "_nocnt"}, {24'd0, err_count}, 32'd0);
    for (int k = 0; k < DEPTH; k++) begin
      inst_acc(BASE + 32'(4 * k), 4'h0, 32'h0);
      check_val({tag, "_zero"}, inst_sram_rdata, 32'h0);
    end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    check_val("rst_irdata", inst_sram_rdata, 32'h0);
    check_val("rst_drdata", data_sram_rdata, 32'h0);
    check_val("rst_init",   {31'd0, init_done}, 32'd0);
    check_val("rst_flag",   {31'd0, err_flag}, 32'd0);
    check_val("rst_cnt",    {24'd0, err_count}, 32'd0);
    reset = 1'b0;
    fill_check("fill1");

    // Write via data port, read back via inst port, then hold.
    data_acc(BASE + 32'h10, 4'hf, 32'hcafef00d);
    check_val("wr_oldval", data_sram_rdata, 32'h0);
    inst_acc(BASE + 32'h10, 4'h0, 32'h0);
    check_val("rd_new", inst_sram_rdata, 32'hcafef00d);
    tick();
    tick();
    check_val("rd_hold", inst_sram_rdata, 32'hcafef00d);
    inst_acc(32'h1fc00013, 4'h0, 32'h0);
    check_val("rd_alias", inst_sram_rdata, 32'hcafef00d);

    // Byte-enable merge.
    data_acc(BASE + 32'h20, 4'hf, 32'h11223344);
    data_acc(BASE + 32'h20, 4'b0101, 32'haabbccdd);
    check_val("be_old", data_sram_rdata, 32'h11223344);
    inst_acc(BASE + 32'h20, 4'h0, 32'h0);
    check_val("be_merge", inst_sram_rdata, 32'h11bb33dd);

    // Same-word collisions: disjoint bytes, then overlapping bytes.
    both_acc(BASE + 32'h30, 4'h1, 32'h000000ff, BASE + 32'h30, 4'hc, 32'hffff0000);
    check_val("col_i_old", inst_sram_rdata, 32'h0);
    check_val("col_d_old", data_sram_rdata, 32'h0);
    data_acc(BASE + 32'h30, 4'h0, 32'h0);
    check_val("col_merge", data_sram_rdata, 32'hffff00ff);
    both_acc(BASE + 32'h34, 4'hf, 32'h11111111, BASE + 32'h34, 4'h3, 32'h22222222);
    inst_acc(BASE + 32'h34, 4'h0, 32'h0);
    check_val("col_prio", inst_sram_rdata, 32'h11112222);

    // Out-of-range accesses and counter saturation.
    data_acc(OOR, 4'h0, 32'h0);
    check_val("oor_rd0",   data_sram_rdata, 32'h0);
    check_val("oor_flag",  {31'd0, err_flag}, 32'd1);
    check_val("oor_cnt1",  {24'd0, err_count}, 32'd1);
    both_acc(32'hbfc00080, 4'h0, 32'h0, OOR, 4'h0, 32'h0);
    check_val("oor_i_rd0", inst_sram_rdata, 32'h0);
    check_val("oor_cnt3",  {24'd0, err_count}, 32'd3);
    data_sram_en = 1'b1; data_sram_addr = OOR;
    repeat (300) tick();
    idle();
    check_val("sat_cnt",   {24'd0, err_count}, 32'h000000ff);
    check_val("sat_flag",  {31'd0, err_flag}, 32'd1);
    check_val("sat_rd0",   data_sram_rdata, 32'h0);
    data_acc(OOR, 4'hf, 32'hdeadbeef);
    inst_acc(BASE + 32'h10, 4'h0, 32'h0);
    check_val("oor_keep",  inst_sram_rdata, 32'hcafef00d);
    inst_acc(BASE, 4'h0, 32'h0);
    check_val("oor_nowr",  inst_sram_rdata, 32'h0);
    inst_acc(BASE + 32'h10, 4'h0, 32'h0);
    check_val("sat_hold",  {24'd0, err_count}, 32'h000000ff);

    // Reset is asynchronous, and a reset mid-fill restarts it.
    reset = 1'b1;
    #1;
    check_val("arst_rdata", inst_sram_rdata, 32'h0);
    check_val("arst_flag",  {31'd0, err_flag}, 32'd0);
    check_val("arst_cnt",   {24'd0, err_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fill_check("fill2");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
